// File: rtl/rv_alu.sv
// rtl/rv_alu.sv - RV32I integer ALU with registered result and zero flag
//
// Purpose: single-cycle integer ALU for the execute stage. The operation is
// selected by a funct3-style op code plus three modifier bits. The result is
// registered, so the answer for an accepted operation appears one clock later.
// A new operation can be accepted every clock.
//
// Ports:
//   clk        - clock; all state changes on the rising edge
//   rst_n      - asynchronous active-low reset
//   in_valid   - op/a/b/modifiers are valid this cycle
//   op         - 000 ADD, 001 SLL, 010 SLT, 011 SLTU,
//                100 XOR, 101 SRL/SRA, 110 OR, 111 AND
//   a, b       - operands
//   b_negate   - ADD only: use ~b instead of b
//   b_add_one  - ADD only: carry-in of 1 (with b_negate this gives a - b)
//   sign       - shift-right only: 1 = arithmetic, 0 = logical
//   out        - registered result; holds when in_valid is low
//   zero_flag  - registered; 1 when out is all zeros
//   out_valid  - registered copy of in_valid

module rv_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_negate,
  input  logic             b_add_one,
  input  logic             sign,
  output logic [WIDTH-1:0] out,
  output logic             zero_flag,
  output logic             out_valid
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_SLT  = 3'b010;
  localparam logic [2:0] OP_SLTU = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SR   = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_AND  = 3'b111;

  // Only the low bits of b select the shift distance; the rest are ignored.
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   sll_res;
  logic [WIDTH-1:0]   srl_res;
  logic [WIDTH-1:0]   sra_res;
  logic               lt_signed;
  logic               lt_unsigned;
  logic [WIDTH-1:0]   result;

  assign shamt = b[SHAMT_W-1:0];

  // Subtraction reuses the adder as a + ~b + 1; carry-out is dropped.
  assign b_eff = b_negate ? ~b : b;
  assign sum   = a + b_eff + {{(WIDTH-1){1'b0}}, b_add_one};

  assign sll_res = a << shamt;
  assign srl_res = a >> shamt;
  assign sra_res = $signed(a) >>> shamt;

  assign lt_signed   = $signed(a) < $signed(b);
  assign lt_unsigned = a < b;

  always_comb begin
    result = '0;
    unique case (op)
      OP_ADD:  result = sum;
      OP_SLL:  result = sll_res;
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, lt_signed};
      OP_SLTU: result = {{(WIDTH-1){1'b0}}, lt_unsigned};
      OP_XOR:  result = a ^ b;
      OP_SR:   result = sign ? sra_res : srl_res;
      OP_OR:   result = a | b;
      OP_AND:  result = a & b;
      default: result = '0;
    endcase
  end

  // out/zero_flag keep the last accepted result while in_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      zero_flag <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out       <= result;
        zero_flag <= (result == '0);
      end
    end
  end

endmodule

// File: tb/tb_rv_alu.sv
// tb/tb_rv_alu.sv - self-checking scoreboard bench for rv_alu

module tb_rv_alu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        b_negate;
  logic        b_add_one;
  logic        sign;
  logic [31:0] out;
  logic        zero_flag;
  logic        out_valid;

  typedef struct packed {
    logic [31:0] v;
    logic        z;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_err;

  rv_alu #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .op        (op),
    .a         (a),
    .b         (b),
    .b_negate  (b_negate),
    .b_add_one (b_add_one),
    .sign      (sign),
    .out       (out),
    .zero_flag (zero_flag),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model written independently of the RTL structure.
  function automatic logic [31:0] model(input logic [2:0] mop,
                                        input logic [31:0] ma,
                                        input logic [31:0] mb,
                                        input logic mneg, input logic mone,
                                        input logic msgn);
    logic [31:0] r;
    int          sh;
    sh = int'(mb % 32);
    case (mop)
      3'd0: r = ma + (mneg ? ~mb : mb) + 32'(mone);
      3'd1: r = ma << sh;
      3'd2: begin
        if (ma[31] != mb[31]) r = ma[31] ? 32'd1 : 32'd0;
        else                  r = (ma < mb) ? 32'd1 : 32'd0;
      end
      3'd3: r = (ma < mb) ? 32'd1 : 32'd0;
      3'd4: r = ma ^ mb;
      3'd5: begin
        r = ma;
        for (int i = 0; i < sh; i++) r = {msgn & ma[31], r[31:1]};
      end
      3'd6: r = ma | mb;
      default: r = ma & mb;
    endcase
    return r;
  endfunction

  // Drive one operation and record its expected result.
  task automatic issue(input logic [2:0] iop, input logic [31:0] ia,
                       input logic [31:0] ib, input logic ineg,
                       input logic ione, input logic isgn);
    exp_t e;
    in_valid  = 1'b1;
    op        = iop;
    a         = ia;
    b         = ib;
    b_negate  = ineg;
    b_add_one = ione;
    sign      = isgn;
    e.v = model(iop, ia, ib, ineg, ione, isgn);
    e.z = (e.v == 32'd0);
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (out !== 32'd0 || zero_flag !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got out=%h z=%b v=%b want 0/1/0",
               out, zero_flag, out_valid);
    end
  endtask

  // Directed vectors from the test plan, one result checked per clock.
  task automatic test_directed();
    logic [2:0]  t_op [14];
    logic [31:0] t_a  [14];
    logic [31:0] t_b  [14];
    logic [2:0]  t_md [14];   // {b_negate, b_add_one, sign}
    logic [31:0] t_ex [14];
    exp_t e;
    t_op = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd5, 3'd5, 3'd1,
             3'd2, 3'd2, 3'd3, 3'd2, 3'd4, 3'd6, 3'd7};
    t_a  = '{32'd30, 32'd30, 32'd20, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
             32'd1, 32'd1, 32'hFFFFFFF6, 32'hFFFFFFF6, 32'd7,
             32'hFFFFFFF6, 32'hFFFFFFFF, 32'hFFFFFFFF};
    t_b  = '{32'd20, 32'd20, 32'd20, 32'd2, 32'd2, 32'd2, 32'h22,
             32'd2, 32'd10, 32'd10, 32'd7, 32'd10, 32'd2, 32'd2};
    t_md = '{3'b000, 3'b110, 3'b110, 3'b001, 3'b000, 3'b001, 3'b110,
             3'b111, 3'b000, 3'b000, 3'b000, 3'b111, 3'b111, 3'b111};
    t_ex = '{32'd50, 32'd10, 32'd0, 32'd4, 32'h3FFFFFFF, 32'hFFFFFFFF,
             32'd4, 32'd1, 32'd1, 32'd0, 32'd0, 32'hFFFFFFFC,
             32'hFFFFFFFF, 32'd2};
    for (int i = 0; i < 14; i++) begin
      issue(t_op[i], t_a[i], t_b[i], t_md[i][2], t_md[i][1], t_md[i][0]);
      step();
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL directed_%0d: scoreboard empty", i);
        continue;
      end
      e = sb.pop_front();
      if (out !== t_ex[i] || out !== e.v || zero_flag !== (t_ex[i] == 0) ||
          out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL directed_%0d: got out=%h z=%b v=%b want %h/%b/1",
                 i, out, zero_flag, out_valid, t_ex[i], t_ex[i] == 0);
      end
    end
  endtask

  task automatic test_ltu_equal();
    exp_t e;
    issue(3'd3, 32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b1);
    step();
    e = sb.pop_front();
    n_cmp++;
    if (out !== 32'd0 || zero_flag !== 1'b1 || out !== e.v) begin
      n_err++;
      $display("FAIL sltu_equal: got out=%h z=%b want 0/1", out, zero_flag);
    end
  endtask

  task automatic test_hold();
    logic [31:0] prev;
    exp_t e;
    issue(3'd6, 32'h00F0, 32'h0F00, 1'b0, 1'b0, 1'b0);
    step();
    e = sb.pop_front();
    prev = e.v;
    in_valid = 1'b0;
    op = 3'd7;
    a  = 32'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (out !== prev || zero_flag !== 1'b0 || out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL hold_%0d: got out=%h z=%b v=%b want %h/0/0",
                 i, out, zero_flag, out_valid, prev);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 7)), $urandom,
            (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom,
            1'($urandom), 1'($urandom), 1'($urandom));
      step();
      e = sb.pop_front();
      n_cmp++;
      if (out !== e.v || zero_flag !== e.z || out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_%0d: op=%0d got out=%h z=%b v=%b want %h/%b/1",
                 i, op, out, zero_flag, out_valid, e.v, e.z);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_mid_reset();
    exp_t e;
    issue(3'd0, 32'd30, 32'd20, 1'b0, 1'b0, 1'b0);
    step();
    e = sb.pop_front();
    n_cmp++;
    if (out !== 32'd50 || out !== e.v || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset: got out=%h v=%b want 50/1", out, out_valid);
    end
    // Another op in flight, then reset between edges.
    issue(3'd4, 32'h1234, 32'h4321, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    n_cmp++;
    if (out !== 32'd0 || zero_flag !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got out=%h z=%b v=%b want 0/1/0",
               out, zero_flag, out_valid);
    end
    step();
    n_cmp++;
    if (out !== 32'd0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_held: got out=%h v=%b want 0/0", out, out_valid);
    end
    rst_n = 1'b1;
    issue(3'd0, 32'd30, 32'd20, 1'b0, 1'b0, 1'b0);
    step();
    e = sb.pop_front();
    n_cmp++;
    if (out !== 32'd50 || out !== e.v || zero_flag !== 1'b0 ||
        out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset_add: got out=%h z=%b v=%b want 50/0/1",
               out, zero_flag, out_valid);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = 3'd0;
    a         = 32'd0;
    b         = 32'd0;
    b_negate  = 1'b0;
    b_add_one = 1'b0;
    sign      = 1'b0;
    #12;
    test_reset();
    rst_n = 1'b1;
    test_directed();
    test_ltu_equal();
    test_hold();
    test_back_to_back();
    test_mid_reset();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rv_alu.md
Name:
rv_alu

Overview:
- 32-bit integer ALU for the RV32I execute stage; covers the register-register and register-immediate integer ops.
- Operation is chosen by a 3-bit funct3-style opcode plus three modifier bits: `b_negate`, `b_add_one`, `sign`.
- Result and zero flag are registered: one-cycle latency, one operation accepted per clock.

Parameters:
- WIDTH, 32, datapath width of `a`, `b` and `out`.
- SHAMT_W, 5, number of low bits of `b` used as the shift amount; must equal log2(WIDTH).

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operands and controls are valid this cycle.
- op  input  3  operation select (encodings under Behaviour).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- b_negate  input  1  for op 000: invert `b` before the add.
- b_add_one  input  1  for op 000: add carry-in of 1.
- sign  input  1  for op 101: 1 selects arithmetic shift, 0 selects logical shift.
- out  output  WIDTH  registered result.
- zero_flag  output  1  registered; 1 when `out` is all zeros.
- out_valid  output  1  registered copy of `in_valid`.

Behaviour:
- Reset (`rst_n` low, asynchronous): `out` = 0, `zero_flag` = 1, `out_valid` = 0. Outputs hold these values until the first rising edge after `rst_n` deasserts.
- Each rising edge with `in_valid` = 1:
  - `out` <= f(op, a, b, modifiers);
  - `zero_flag` <= (f == 0);
  - `out_valid` <= 1.
- Each rising edge with `in_valid` = 0: `out` and `zero_flag` hold their previous values; `out_valid` <= 0.
- Latency is exactly 1 cycle; there is no backpressure.
- op encodings:
  - 000 ADD: a + (b_negate ? ~b : b) + b_add_one, modulo 2^WIDTH, carry discarded. b_negate = b_add_one = 1 gives a − b.
  - 001 SLL: a << b[SHAMT_W-1:0].
  - 010 SLT: 1 if $signed(a) < $signed(b), else 0; zero-extended to WIDTH.
  - 011 SLTU: 1 if a < b unsigned, else 0.
  - 100 XOR: a ^ b.
  - 101 SRL/SRA: a >> b[SHAMT_W-1:0]. Vacated MSBs are filled with a[WIDTH-1] when `sign` = 1, and with 0 when `sign` = 0.
  - 110 OR: a | b.
  - 111 AND: a & b.
- Modifier scope:
  - `b_negate` and `b_add_one` affect op 000 only.
  - `sign` affects op 101 only.
  - Every other op ignores all three.
- Shift amount:
  - Only b[4:0] is used; upper bits of `b` are ignored (b = 33 shifts by 1).
  - A shift amount of 0 returns `a` unchanged.
- Overflow: no overflow or carry output; wrap-around is silent.
- Comparisons with a == b return 0 for both SLT and SLTU.
- Reset asserted mid-stream: outputs go to reset values immediately, and the in-flight result is discarded.
- Reset release: the first `in_valid` cycle after release produces a valid result on the next edge.

Test Plan:
- Add/sub:
  - a=30, b=20, op=000, modifiers 0 -> out=50, zero_flag=0 one cycle later.
  - Same operands with b_negate=b_add_one=1 -> out=10.
  - a=b=20 with the same modifiers -> out=0, zero_flag=1.
- Shifts:
  - a=1, b=2, op=001 -> out=4.
  - a=0xFFFFFFFF, b=2, op=101, sign=0 -> out=0x3FFFFFFF.
  - Same with sign=1 -> out=0xFFFFFFFF.
  - b=0x22 with op=001 -> shifts by 2.
- Compares:
  - a=1, b=2, op=010 -> out=1.
  - a=−10 (0xFFFFFFF6), b=10, op=010 -> out=1.
  - Same operands, op=011 -> out=0, zero_flag=1.
  - a=b -> 0 for both ops.
- Logic:
  - a=0xFFFFFFF6, b=10, op=100 -> out=0xFFFFFFFC.
  - a=0xFFFFFFFF, b=2, op=110 -> out=0xFFFFFFFF.
  - Same operands, op=111 -> out=2.
- Handshake:
  - Back-to-back `in_valid` cycles produce one result per cycle, each aligned with `out_valid`.
  - Dropping `in_valid` holds `out` and clears `out_valid`.
- Reset:
  - Assert `rst_n`=0 between clock edges while out=50 -> out=0, zero_flag=1, out_valid=0 immediately, without waiting for a clock edge.
  - After release, the next ADD result appears after 1 cycle.
